// File: rtl/mesh_loader.sv
// mesh_loader: packs an 18-byte stream into 144-bit triangle words and writes them to the mesh RAM.
// Optional trailer checksum check is enabled by defining MESH_LOADER_CHECKSUM_EN.
module mesh_loader #(
  parameter int MAX_COUNT = 1024,
  localparam int AW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start_in,
  input  logic [AW:0]   num_tris_in,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid_in,
  output logic          byte_ready_out,
  output logic          wr_en_out,
  output logic [AW-1:0] wr_addr_out,
  output logic [143:0]  wr_data_out,
  output logic [AW:0]   tri_count_out,
  output logic          busy_out,
  output logic          done_out,
  output logic          overflow_out,
  output logic          checksum_err_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
`ifdef MESH_LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  // State entered once the payload is complete (trailer check when enabled).
`ifdef MESH_LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CHECK;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  localparam logic [AW:0] MAX_N    = (AW+1)'(MAX_COUNT);
  localparam logic [4:0]  LAST_IDX = 5'd17;

  state_t          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [AW:0]     n_q, n_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW:0]     count_q, count_d;
  logic [143:0]    data_q, data_d;
  logic            ovf_q, ovf_d;
  logic            ready_q, ready_d;
  logic            wr_en_q, wr_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            byte_fire_s;
  logic [AW:0]     count_inc_s;
`ifdef MESH_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
  logic            cerr_q, cerr_d;
`endif

  assign byte_fire_s = byte_valid_in && ready_q;
  assign count_inc_s = count_q + 1'b1;

  // Next-state and next-output logic; output strobes are decoded from state_d so they are registered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    addr_d  = addr_q;
    count_d = count_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
`ifdef MESH_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    cerr_d  = cerr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          if (num_tris_in > MAX_N) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d   = 1'b0;
            idx_d   = 5'd0;
            addr_d  = '0;
            count_d = '0;
            n_d     = num_tris_in;
`ifdef MESH_LOADER_CHECKSUM_EN
            csum_d  = 8'h00;
            cerr_d  = 1'b0;
`endif
            state_d = (num_tris_in == '0) ? S_FINAL : S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (byte_fire_s) begin
          data_d[{idx_q, 3'b000} +: 8] = byte_in;
          idx_d = idx_q + 5'd1;
`ifdef MESH_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_in;
`endif
          state_d = (idx_q == LAST_IDX) ? S_WRITE : S_LOAD;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WRITE: begin
        count_d = count_inc_s;
        idx_d   = 5'd0;
        // The address advances only when another triangle follows, so it never wraps.
        if (count_inc_s < n_q) begin
          addr_d  = addr_q + 1'b1;
          state_d = S_LOAD;
        end else begin
          state_d = S_FINAL;
        end
      end
`ifdef MESH_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (byte_fire_s) begin
          cerr_d  = (byte_in != csum_q);
          state_d = S_DONE;
        end else begin
          state_d = S_CHECK;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_LOAD);
`ifdef MESH_LOADER_CHECKSUM_EN
    if (state_d == S_CHECK) begin
      ready_d = 1'b1;
    end else begin
      ready_d = (state_d == S_LOAD);
    end
`endif
    wr_en_d = (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and output registers; reset aborts a load with no further write strobes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      idx_q   <= 5'd0;
      n_q     <= '0;
      addr_q  <= '0;
      count_q <= '0;
      data_q  <= 144'd0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MESH_LOADER_CHECKSUM_EN
      csum_q  <= 8'h00;
      cerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MESH_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      cerr_q  <= cerr_d;
`endif
    end
  end

  assign byte_ready_out = ready_q;
  assign wr_en_out      = wr_en_q;
  assign wr_addr_out    = addr_q;
  assign wr_data_out    = data_q;
  assign tri_count_out  = count_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign overflow_out   = ovf_q;
`ifdef MESH_LOADER_CHECKSUM_EN
  assign checksum_err_out = cerr_q;
`else
  assign checksum_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_mesh_loader.sv
// Scoreboard bench for mesh_loader: expected RAM writes are queued as bytes are driven and
// compared when wr_en_out strobes.
module tb_mesh_loader;
  localparam int MAXC = 4;
  localparam int AW   = 2;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic [AW:0]   num_tris_in;
  logic [7:0]    byte_in;
  logic          byte_valid_in;
  logic          byte_ready_out;
  logic          wr_en_out;
  logic [AW-1:0] wr_addr_out;
  logic [143:0]  wr_data_out;
  logic [AW:0]   tri_count_out;
  logic          busy_out;
  logic          done_out;
  logic          overflow_out;
  logic          checksum_err_out;

  typedef struct {
    logic [AW-1:0] addr;
    logic [143:0]  data;
  } wr_t;

  wr_t        exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_writes = 0;
  int         exp_writes = 0;
  logic [7:0] csum_acc;

  mesh_loader #(.MAX_COUNT(MAXC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .num_tris_in(num_tris_in),
    .byte_in(byte_in), .byte_valid_in(byte_valid_in), .byte_ready_out(byte_ready_out),
    .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .tri_count_out(tri_count_out), .busy_out(busy_out), .done_out(done_out),
    .overflow_out(overflow_out), .checksum_err_out(checksum_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the oldest queued triangle.
  always @(negedge clk_in) begin
    if (!rst_in && wr_en_out) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_write", {{(144-AW){1'b0}}, wr_addr_out}, 144'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_val("wr_addr", {{(144-AW){1'b0}}, wr_addr_out}, {{(144-AW){1'b0}}, e.addr});
        check_val("wr_data", wr_data_out, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_start(input int n);
    start_in    = 1'b1;
    num_tris_in = (AW+1)'(n);
    csum_acc    = 8'h00;
    step();
    start_in    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int guard = 0;
    if (gap) begin
      byte_valid_in = 1'b0;
      step();
    end
    byte_in       = b;
    byte_valid_in = 1'b1;
    while (!byte_ready_out && guard < 100) begin
      step();
      guard++;
    end
    if (!byte_ready_out) check_val("ready_timeout", 144'd0, 144'd1);
    step();
    byte_valid_in = 1'b0;
  endtask

  task automatic load(input int n, input bit gap, input bit seq);
    for (int t = 0; t < n; t++) begin
      wr_t e;
      logic [143:0] word = 144'd0;
      for (int k = 0; k < 18; k++) begin
        logic [7:0] b;
        b = seq ? 8'(k) : 8'($urandom_range(0, 255));
        word[8*k +: 8] = b;
        csum_acc = csum_acc ^ b;
        if (k == 17) begin
          e.addr = AW'(t);
          e.data = word;
          exp_q.push_back(e);
          exp_writes++;
        end
        send_byte(b, gap);
      end
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done_out && cyc < 500) begin
      step();
      cyc++;
    end
    check_val("done_seen", {143'd0, done_out}, 144'd1);
    check_val("busy_at_done", {143'd0, busy_out}, 144'd0);
    step();
    check_val("done_pulse_len", {143'd0, done_out}, 144'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ready"}, {143'd0, byte_ready_out}, 144'd0);
    check_val({tag, "_wr_en"}, {143'd0, wr_en_out}, 144'd0);
    check_val({tag, "_addr"}, {{(144-AW){1'b0}}, wr_addr_out}, 144'd0);
    check_val({tag, "_data"}, wr_data_out, 144'd0);
    check_val({tag, "_count"}, {{(143-AW){1'b0}}, tri_count_out}, 144'd0);
    check_val({tag, "_busy"}, {143'd0, busy_out}, 144'd0);
    check_val({tag, "_done"}, {143'd0, done_out}, 144'd0);
    check_val({tag, "_ovf"}, {143'd0, overflow_out}, 144'd0);
    check_val({tag, "_cerr"}, {143'd0, checksum_err_out}, 144'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int wr_before;
    rst_in = 1'b1; start_in = 1'b0; num_tris_in = '0; byte_in = 8'h00; byte_valid_in = 1'b0;
    csum_acc = 8'h00;
    repeat (2) step();
    check_reset_vals("rst");
    rst_in = 1'b0;
    step();
    check_val("idle_ready", {143'd0, byte_ready_out}, 144'd0);

    // N=1, sequential bytes with valid held high
    pulse_start(1);
    check_val("t1_busy", {143'd0, busy_out}, 144'd1);
    check_val("t1_ready", {143'd0, byte_ready_out}, 144'd1);
    load(1, 1'b0, 1'b1);
    check_val("t1_wr_en_lat", {143'd0, wr_en_out}, 144'd1);
    check_val("t1_ready_in_write", {143'd0, byte_ready_out}, 144'd0);
`ifdef MESH_LOADER_CHECKSUM_EN
    send_byte(csum_acc, 1'b0);
    wait_done(cyc);
`else
    step();
    check_val("t1_ready_after_last", {143'd0, byte_ready_out}, 144'd0);
    check_val("t1_done_lat", {143'd0, done_out}, 144'd1);
    wait_done(cyc);
    check_val("t1_done_cycles", 144'(cyc), 144'd0);
`endif
    check_val("t1_count", {{(143-AW){1'b0}}, tri_count_out}, 144'd1);

    // N=3 with valid toggling
    pulse_start(3);
    load(3, 1'b1, 1'b0);
`ifdef MESH_LOADER_CHECKSUM_EN
    send_byte(csum_acc, 1'b0);
`endif
    wait_done(cyc);
    check_val("t2_count", {{(143-AW){1'b0}}, tri_count_out}, 144'd3);
    check_val("t2_last_addr", {{(144-AW){1'b0}}, wr_addr_out}, 144'd2);
    check_val("t2_cerr", {143'd0, checksum_err_out}, 144'd0);

    // N=0
    wr_before = n_writes;
    pulse_start(0);
`ifdef MESH_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
    wait_done(cyc);
`else
    wait_done(cyc);
    check_val("t3_done_cycles", 144'(cyc), 144'd0);
`endif
    check_val("t3_no_writes", 144'(n_writes), 144'(wr_before));
    check_val("t3_count", {{(143-AW){1'b0}}, tri_count_out}, 144'd0);
    check_val("t3_cerr", {143'd0, checksum_err_out}, 144'd0);

    // overflow then a full-capacity load
    wr_before = n_writes;
    pulse_start(5);
    check_val("t4_ovf", {143'd0, overflow_out}, 144'd1);
    check_val("t4_busy", {143'd0, busy_out}, 144'd0);
    check_val("t4_ready", {143'd0, byte_ready_out}, 144'd0);
    repeat (5) step();
    check_val("t4_no_writes", 144'(n_writes), 144'(wr_before));
    check_val("t4_ovf_sticky", {143'd0, overflow_out}, 144'd1);
    pulse_start(4);
    check_val("t4_ovf_clear", {143'd0, overflow_out}, 144'd0);
    load(4, 1'b0, 1'b0);
`ifdef MESH_LOADER_CHECKSUM_EN
    send_byte(csum_acc, 1'b0);
`endif
    wait_done(cyc);
    check_val("t4_count", {{(143-AW){1'b0}}, tri_count_out}, 144'd4);
    check_val("t4_last_addr", {{(144-AW){1'b0}}, wr_addr_out}, 144'd3);

    // reset after byte 9 of the third triangle
    pulse_start(3);
    load(2, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    rst_in = 1'b1;
    #1;
    check_reset_vals("midrst");
    step();
    rst_in = 1'b0;
    step();
    check_val("midrst_queue_empty", 144'(exp_q.size()), 144'd0);
    pulse_start(1);
    load(1, 1'b0, 1'b0);
`ifdef MESH_LOADER_CHECKSUM_EN
    send_byte(csum_acc, 1'b0);
`endif
    wait_done(cyc);
    check_val("t5_count", {{(143-AW){1'b0}}, tri_count_out}, 144'd1);

`ifdef MESH_LOADER_CHECKSUM_EN
    pulse_start(2);
    load(2, 1'b0, 1'b0);
    send_byte(csum_acc ^ 8'h5A, 1'b0);
    check_val("t6_cerr_at_done", {143'd0, checksum_err_out}, 144'd1);
    wait_done(cyc);
    pulse_start(2);
    check_val("t6_cerr_cleared", {143'd0, checksum_err_out}, 144'd0);
    load(2, 1'b1, 1'b0);
    send_byte(csum_acc, 1'b0);
    wait_done(cyc);
    check_val("t6_cerr_good", {143'd0, checksum_err_out}, 144'd0);
`endif

    repeat (3) step();
    check_val("final_queue_empty", 144'(exp_q.size()), 144'd0);
    check_val("final_write_count", 144'(n_writes), 144'(exp_writes));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
